// File: rtl/qif_sched_pkg.sv
// qif_sched_pkg: shared FSM encoding, default neuron constants and index width helper.
package qif_sched_pkg;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WB, DONE} state_e;
    localparam logic [7:0] V_THRESH_DEF       = 8'd200;
    localparam logic [7:0] V_RESET_DEF        = 8'd0;
    localparam logic [3:0] REFRACT_SWEEPS_DEF = 4'd4;
    function automatic int idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/qif_state_bank.sv
// qif_state_bank: per-neuron V/I/refract registers; refract storage exists only
// when QIF_SCHED_REFRACTORY_EN is defined.
module qif_state_bank
    import qif_sched_pkg::*;
#(
    parameter int         N      = 4,
    parameter int         IW     = idx_w(N),
    parameter logic [7:0] V_INIT = 8'd0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          v_we,
    input  logic [IW-1:0] v_widx,
    input  logic [7:0]    v_wdata,
    input  logic          r_we,
    input  logic [IW-1:0] r_widx,
    input  logic [3:0]    r_wdata,
    input  logic          i_we,
    input  logic [IW-1:0] i_widx,
    input  logic [7:0]    i_wdata,
    input  logic [IW-1:0] rd_idx,
    input  logic [IW-1:0] obs_idx,
    output logic [7:0]    v_rd,
    output logic [7:0]    i_rd,
    output logic [3:0]    r_rd,
    output logic [7:0]    v_obs_rd
);
    logic [7:0] v_q [N];
    logic [7:0] v_d [N];
    logic [7:0] i_q [N];
    logic [7:0] i_d [N];

    always_comb begin
        v_d = v_q;
        i_d = i_q;
        if (v_we) v_d[v_widx] = v_wdata;
        if (i_we) i_d[i_widx] = i_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '{default: V_INIT};
            i_q <= '{default: 8'd0};
        end else begin
            v_q <= v_d;
            i_q <= i_d;
        end
    end

    assign v_rd     = v_q[rd_idx];
    assign i_rd     = i_q[rd_idx];
    assign v_obs_rd = v_q[obs_idx];

`ifdef QIF_SCHED_REFRACTORY_EN
    logic [3:0] r_q [N];
    logic [3:0] r_d [N];

    always_comb begin
        r_d = r_q;
        if (r_we) r_d[r_widx] = r_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_q <= '{default: 4'd0};
        else        r_q <= r_d;
    end

    assign r_rd = r_q[rd_idx];
`else
    logic unused_r;
    assign unused_r = ^{r_we, r_widx, r_wdata};
    assign r_rd     = 4'd0;
`endif
endmodule

// File: rtl/qif_neuron_scheduler.sv
// qif_neuron_scheduler: sweeps NUM_NEURONS virtual QIF neurons through one external
// datapath per tick; refractory skipping is enabled by QIF_SCHED_REFRACTORY_EN.
module qif_neuron_scheduler
    import qif_sched_pkg::*;
#(
    parameter int         NUM_NEURONS    = 4,
    parameter logic [7:0] V_THRESH       = V_THRESH_DEF,
    parameter logic [7:0] V_RESET        = V_RESET_DEF,
    parameter logic [3:0] REFRACT_SWEEPS = REFRACT_SWEEPS_DEF,
    parameter int         IW             = idx_w(NUM_NEURONS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic                   tick,
    input  logic                   i_wr,
    input  logic [IW-1:0]          i_idx,
    input  logic [7:0]             i_data,
    output logic                   dp_start,
    output logic [7:0]             dp_v,
    output logic [7:0]             dp_i,
    input  logic                   dp_done,
    input  logic [7:0]             dp_v_next,
    output logic                   busy,
    output logic                   sweep_done,
    output logic [NUM_NEURONS-1:0] spike_vec,
    output logic                   tick_overrun,
    input  logic [IW-1:0]          v_sel,
    output logic [7:0]             v_obs
);
    state_e                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d, rd_idx;
    logic [NUM_NEURONS-1:0] acc_q, acc_d, spike_q, spike_d;
    logic [7:0]             dp_v_q, dp_v_d, dp_i_q, dp_i_d, res_q, res_d, v_obs_q, v_obs_d;
    logic                   dp_start_q, dp_start_d, skip_q, skip_d, busy_q, busy_d;
    logic                   done_q, done_d, ovr_q, ovr_d;
    logic                   v_we, r_we, fire, last;
    logic [7:0]             v_wdata, v_rd, i_rd, v_obs_rd;
    logic [3:0]             r_wdata, r_rd;

    // Read address anticipates the next ISSUE so dp_v/dp_i can be latched on entry.
    assign rd_idx = (state_q == WB) ? idx_q + 1'b1 : ((state_q == IDLE) ? '0 : idx_q);
    assign fire   = res_q >= V_THRESH;
    assign last   = idx_q == IW'(NUM_NEURONS - 1);

    qif_state_bank #(.N(NUM_NEURONS), .IW(IW), .V_INIT(V_RESET)) u_bank (
        .clk(clk), .rst_n(rst_n),
        .v_we(v_we), .v_widx(idx_q), .v_wdata(v_wdata),
        .r_we(r_we), .r_widx(idx_q), .r_wdata(r_wdata),
        .i_we(i_wr), .i_widx(i_idx), .i_wdata(i_data),
        .rd_idx(rd_idx), .obs_idx(v_sel),
        .v_rd(v_rd), .i_rd(i_rd), .r_rd(r_rd), .v_obs_rd(v_obs_rd)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        acc_d      = acc_q;
        spike_d    = spike_q;
        dp_v_d     = dp_v_q;
        dp_i_d     = dp_i_q;
        res_d      = res_q;
        skip_d     = skip_q;
        dp_start_d = 1'b0;
        ovr_d      = ovr_q | (tick & (state_q != IDLE));
        v_we       = 1'b0;
        v_wdata    = fire ? V_RESET : res_q;
        r_we       = 1'b0;
        r_wdata    = REFRACT_SWEEPS;
        case (state_q)
            IDLE: if (tick & ena) begin
                state_d = ISSUE;
                idx_d   = '0;
                acc_d   = '0;
            end
            ISSUE: begin
                skip_d  = !dp_start_q;
                state_d = dp_start_q ? WAIT : WB;
                r_we    = !dp_start_q;
                r_wdata = r_rd - 4'd1;
            end
            WAIT: if (dp_done) begin
                res_d   = dp_v_next;
                state_d = WB;
            end
            WB: begin
                v_we    = !skip_q;
                r_we    = !skip_q & fire;
                if (!skip_q & fire) acc_d[idx_q] = 1'b1;
                state_d = last ? DONE : ISSUE;
                idx_d   = last ? idx_q : idx_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (state_d == ISSUE) begin
            dp_v_d     = v_rd;
            dp_i_d     = i_rd;
            dp_start_d = r_rd == 4'd0;
        end
        if (state_d == DONE) spike_d = acc_d;
        busy_d  = state_d != IDLE;
        done_d  = state_d == DONE;
        v_obs_d = v_obs_rd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            acc_q      <= '0;
            spike_q    <= '0;
            dp_v_q     <= '0;
            dp_i_q     <= '0;
            res_q      <= '0;
            skip_q     <= 1'b0;
            dp_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
            v_obs_q    <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            spike_q    <= spike_d;
            dp_v_q     <= dp_v_d;
            dp_i_q     <= dp_i_d;
            res_q      <= res_d;
            skip_q     <= skip_d;
            dp_start_q <= dp_start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovr_q      <= ovr_d;
            v_obs_q    <= v_obs_d;
        end
    end

    assign dp_start     = dp_start_q;
    assign dp_v         = dp_v_q;
    assign dp_i         = dp_i_q;
    assign busy         = busy_q;
    assign sweep_done   = done_q;
    assign spike_vec    = spike_q;
    assign tick_overrun = ovr_q;
    assign v_obs        = v_obs_q;
endmodule

// File: tb/tb_qif_neuron_scheduler.sv
// tb_qif_neuron_scheduler: directed scoreboard bench with a 2-cycle saturating-add datapath.
module tb_qif_neuron_scheduler;
    typedef struct packed {
        int         idx;
        logic [7:0] v;
        logic [7:0] i;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n, ena, tick, i_wr, dp_done, dp_done_m, dp_done_x;
    logic [1:0] i_idx, v_sel;
    logic [7:0] i_data, dp_v, dp_i, dp_v_next, v_obs;
    logic       dp_start, busy, sweep_done, tick_overrun;
    logic [3:0] spike_vec;

    int checks = 0, failures = 0, cycle = 0, t0 = 0, lat = 0;
    int n_sweeps = 0, exp_sweeps = 0, issued_idx = -1;
    exp_t       sbq[$];
    logic [3:0] spq[$];
    logic [7:0] mv[4], mi[4];
    int         mr[4];

    assign dp_done = dp_done_m | dp_done_x;

    qif_neuron_scheduler dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .tick(tick),
        .i_wr(i_wr), .i_idx(i_idx), .i_data(i_data),
        .dp_start(dp_start), .dp_v(dp_v), .dp_i(dp_i),
        .dp_done(dp_done), .dp_v_next(dp_v_next),
        .busy(busy), .sweep_done(sweep_done), .spike_vec(spike_vec),
        .tick_overrun(tick_overrun), .v_sel(v_sel), .v_obs(v_obs)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 4; n++) begin
            mv[n] = 8'd0;
            mi[n] = 8'd0;
            mr[n] = 0;
        end
    endtask

    task automatic model_sweep();
        logic [3:0] spk = 4'd0;
        int r;
        for (int n = 0; n < 4; n++) begin
`ifdef QIF_SCHED_REFRACTORY_EN
            if (mr[n] != 0) begin
                mr[n]--;
                continue;
            end
`endif
            sbq.push_back('{n, mv[n], mi[n]});
            r = int'(mv[n]) + int'(mi[n]);
            if (r > 255) r = 255;
            if (r >= 200) begin
                mv[n]  = 8'd0;
                spk[n] = 1'b1;
                mr[n]  = 4;
            end else mv[n] = 8'(r);
        end
        spq.push_back(spk);
    endtask

    task automatic write_i(input int n, input logic [7:0] val);
        i_wr = 1'b1; i_idx = 2'(n); i_data = val;
        @(negedge clk);
        i_wr = 1'b0;
        mi[n] = val;
    endtask

    task automatic start_tick();
        model_sweep();
        exp_sweeps++;
        t0 = cycle;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (sweep_done !== 1'b1 && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("sweep_within_budget", 32'(k < 300), 1);
        lat = cycle - t0;
        @(negedge clk);
    endtask

    task automatic wait_issue(input int n);
        int k = 0;
        while (issued_idx != n && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("issue_within_budget", 32'(k < 100), 1);
    endtask

    task automatic check_v(input int n, input logic [7:0] expv);
        v_sel = 2'(n);
        @(negedge clk);
        chk($sformatf("V%0d", n), v_obs, expv);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_dp_start"}, dp_start, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_sweep_done"}, sweep_done, 0);
        chk({tag, "_spike_vec"}, spike_vec, 0);
        chk({tag, "_tick_overrun"}, tick_overrun, 0);
        chk({tag, "_v_obs"}, v_obs, 0);
        chk({tag, "_dp_v"}, dp_v, 0);
        chk({tag, "_dp_i"}, dp_i, 0);
    endtask

    // Datapath model: pops the expected operands on each dp_start and answers 2 cycles later.
    initial begin
        exp_t       e;
        logic [7:0] v, i;
        int         r;
        bit         ok;
        dp_done_m = 1'b0;
        dp_v_next = 8'd0;
        forever begin
            @(negedge clk);
            if (dp_start === 1'b1) begin
                if (sbq.size() == 0) chk("dp_start_unexpected", 1, 0);
                else begin
                    e = sbq.pop_front();
                    issued_idx = e.idx;
                    chk($sformatf("dp_v_n%0d", e.idx), dp_v, e.v);
                    chk($sformatf("dp_i_n%0d", e.idx), dp_i, e.i);
                end
                v  = dp_v;
                i  = dp_i;
                ok = 1'b1;
                repeat (2) begin
                    @(negedge clk);
                    ok = ok & (rst_n === 1'b1);
                    if (ok) begin
                        chk("dp_v_stable", dp_v, v);
                        chk("dp_i_stable", dp_i, i);
                        chk("dp_start_single", dp_start, 0);
                    end
                end
                r = int'(v) + int'(i);
                dp_v_next = (r > 255) ? 8'd255 : 8'(r);
                dp_done_m = 1'b1;
                @(negedge clk);
                dp_done_m = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (sweep_done === 1'b1) begin
                n_sweeps++;
                if (spq.size() == 0) chk("sweep_done_unexpected", 1, 0);
                else chk("spike_vec", spike_vec, spq.pop_front());
            end
        end
    end

    initial begin
`ifdef QIF_SCHED_REFRACTORY_EN
        logic [7:0] ev[9] = '{8'd60, 8'd120, 8'd180, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd60};
`else
        logic [7:0] ev[9] = '{8'd60, 8'd120, 8'd180, 8'd0, 8'd60, 8'd120, 8'd180, 8'd0, 8'd60};
`endif
        rst_n = 1'b0; ena = 1'b1; tick = 1'b0; i_wr = 1'b0; i_idx = 2'd0;
        i_data = 8'd0; dp_done_x = 1'b0; v_sel = 2'd0;
        model_reset();
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        ena = 1'b0;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        chk("tick_no_ena_busy", busy, 0);
        chk("tick_no_ena_overrun", tick_overrun, 0);
        ena = 1'b1;

        write_i(0, 8'd60);
        for (int s = 0; s < 9; s++) begin
            start_tick();
            wait_done();
            if (s == 0) chk("latency_first", lat, 17);
            check_v(0, ev[s]);
        end

        start_tick();
        wait_issue(0);
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        chk("tick_overrun_set", tick_overrun, 1);
        wait_done();
        chk("sweep_count_overrun", n_sweeps, exp_sweeps);
        start_tick();
        wait_done();
        chk("sweep_count_b2b", n_sweeps, exp_sweeps);
        check_v(0, 8'd180);

        dp_done_x = 1'b1;
        @(negedge clk);
        dp_done_x = 1'b0;
        chk("idle_done_busy", busy, 0);
        chk("idle_done_start", dp_start, 0);
        @(negedge clk);
        chk("idle_done_sweep", sweep_done, 0);
        check_v(0, 8'd180);
        chk("overrun_sticky", tick_overrun, 1);

        write_i(1, 8'd10);
        start_tick();
        wait_issue(1);
        @(negedge clk);
        i_wr = 1'b1; i_idx = 2'd1; i_data = 8'd50;
        @(negedge clk);
        i_wr = 1'b0;
        mi[1] = 8'd50;
        wait_done();
        check_v(0, 8'd0);
        check_v(1, 8'd10);
        start_tick();
        wait_done();
        check_v(1, 8'd60);

        start_tick();
        wait_issue(1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_zero_outputs("midreset");
        sbq.delete();
        spq.delete();
        model_reset();
        exp_sweeps--;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset_busy", busy, 0);
        for (int n = 0; n < 4; n++) check_v(n, 8'd0);

        write_i(2, 8'd100);
        start_tick();
        wait_done();
        chk("latency_no_skip", lat, 17);
        check_v(2, 8'd100);

        repeat (3) @(negedge clk);
        chk("sb_drained", sbq.size(), 0);
        chk("spike_q_drained", spq.size(), 0);
        chk("sweep_count_final", n_sweeps, exp_sweeps);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/qif_neuron_scheduler.md
# qif_neuron_scheduler

Time-multiplexes one external quadratic integrate-and-fire (QIF) update datapath across NUM_NEURONS virtual neurons. The block stores each neuron's membrane voltage, synaptic current and refractory count. On every `tick` it sweeps all neurons in index order through the datapath with a start/done handshake. It applies threshold/reset and reports spikes. It sits between the top-level pin wrapper and the QIF arithmetic block.

## Interface
- NUM_NEURONS, 4: virtual neuron count, power of two, 2..16.
- V_THRESH, 8'd200: spike threshold, unsigned.
- V_RESET, 8'd0: post-spike membrane value.
- REFRACT_SWEEPS, 4'd4: sweeps a neuron is skipped after spiking.
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ena  in  1  gates `tick` acceptance only; an in-flight sweep always completes.
- tick  in  1  one-cycle strobe starting a sweep.
- i_wr  in  1  synaptic current write strobe.
- i_idx  in  log2(N)  write target neuron.
- i_data  in  8  unsigned synaptic current.
- dp_start  out  1  one-cycle request to the datapath.
- dp_v  out  8  membrane value for the datapath; stable from dp_start until dp_done.
- dp_i  out  8  current for the datapath; stable from dp_start until dp_done.
- dp_done  in  1  datapath result valid.
- dp_v_next  in  8  datapath result, sampled when dp_done is high.
- busy  out  1  high from the cycle after tick acceptance through DONE.
- sweep_done  out  1  one-cycle pulse at sweep end.
- spike_vec  out  N  spikes of the last completed sweep; held until the next DONE.
- tick_overrun  out  1  sticky; set when `tick` arrives while busy; cleared by reset only.
- v_sel  in  log2(N)  observation select.
- v_obs  out  8  registered V[v_sel], 1-cycle latency.

## Operation
- **Reset:** all V = V_RESET, all I = 0, all refract = 0, FSM in IDLE. dp_start, busy, sweep_done, spike_vec, tick_overrun and v_obs are all 0; dp_v and dp_i are 0.
- **FSM states:** IDLE, ISSUE, WAIT, WB, DONE.
  - IDLE: `tick & ena` → ISSUE with idx = 0 and spike accumulator cleared. `tick & ~ena` is ignored.
  - ISSUE: if refract[idx] ≠ 0, decrement it and go to WB as a skip (V is unchanged, no dp_start). Otherwise pulse dp_start, latch dp_v = V[idx] and dp_i = I[idx], and go to WAIT.
  - WAIT: hold until dp_done, then → WB.
  - WB, non-skip: if dp_v_next ≥ V_THRESH, set V[idx] = V_RESET, refract[idx] = REFRACT_SWEEPS, and set accumulator bit idx. Otherwise V[idx] = dp_v_next.
  - WB, end of step: if idx = N−1 → DONE, else idx+1 → ISSUE.
  - DONE: copy the accumulator to spike_vec, pulse sweep_done, → IDLE.
- `dp_done` outside WAIT is ignored.
- An `i_wr` takes effect the next cycle in any state. A write to the neuron currently in WAIT does not change the latched dp_i. Simultaneous `i_wr` and WB touch different arrays, so there is no conflict.
- `tick` while busy (including DONE) sets tick_overrun and is dropped.
- Asserting rst_n low mid-sweep aborts immediately to reset values. A late dp_done after reset is ignored.
- Comparison is unsigned 8-bit. dp_v_next is taken as-is, with no saturation in this block.

## Timing
- Tick accepted in cycle t: ISSUE at t+1, dp_start high at t+1.
- Non-skipped neuron takes 2 + L cycles, where L ≥ 1 is cycles from dp_start to dp_done. Skipped neuron takes 2 cycles (ISSUE, WB).
- sweep_done and the spike_vec update occur in the cycle after the last WB. busy falls in the same cycle that IDLE is re-entered.
- The earliest accepted back-to-back tick is the cycle after DONE.

## Configuration
- QIF_SCHED_REFRACTORY_EN defined: refractory counters exist and behave as above.
- QIF_SCHED_REFRACTORY_EN undefined: no refract storage and no skip path; REFRACT_SWEEPS is ignored. Every neuron issues to the datapath every sweep, and a spike only resets V.

## Structure
- Package `qif_sched_pkg`: FSM state enum, default V_THRESH/V_RESET/REFRACT_SWEEPS constants, neuron index width function.
- Sub-module `qif_state_bank` holds the V/I/refract register arrays. It has one write port each for V and refract (WB), one port for I (i_wr), and read ports for idx and v_sel.

## Test plan
Bench datapath model: dp_v_next = dp_v + dp_i (saturating at 255), dp_done 2 cycles after dp_start. N = 4 with default parameters.
- **Ramp to spike:** I[0] = 60, four ticks → V0 = 60, 120, 180; spike_vec = 4'b0001 after sweep 4 (240 ≥ 200); V0 = 0.
- **Refractory:** after that spike, four more ticks → no dp_start for idx 0 and V0 stays 0. Sweep 9 resumes and gives V0 = 60. With the macro undefined, sweep 5 gives V0 = 60.
- **Overrun:** tick during WAIT → tick_overrun = 1 and the sweep count is unchanged; a tick after sweep_done is accepted.
- **Handshake:** dp_done pulsed in IDLE → no state change; dp_v and dp_i stable until dp_done; dp_start pulses exactly once per non-skipped neuron.
- **Mid-sweep write and reset:** i_wr to idx 1 during its WAIT → dp_i unchanged, new value used next sweep. rst_n low in WAIT → all outputs 0, V = 0, FSM in IDLE.
- **Sweep latency:** no skips gives 4 × 4 + 1 = 17 cycles from tick to sweep_done.
